// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant between fetch and data requesters.
// Round-robin selection is built only when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_valid,
  input  logic d_valid,
  input  logic last_owner,
  output logic gnt_valid,
  output logic gnt_owner
);

  assign gnt_valid = i_valid | d_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt_owner = d_valid ? OWN_D : OWN_I;
    // on contention the requester that did not win last time goes first
    if (i_valid && d_valid) gnt_owner = ~last_owner;
  end
`else
  logic unused_last;
  assign unused_last = last_owner;
  // data access belongs to an older instruction, so it wins
  assign gnt_owner   = d_valid ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data requests onto one single-ported memory, one
// transaction outstanding. Optional round-robin via MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_LEN-1:0] i_addr,
  output logic                i_resp_valid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_LEN-1:0] d_addr,
  input  logic                d_wen,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_resp_valid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic                mem_rvalid,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  state_t              state, state_nxt;
  logic                owner, last_owner;
  logic                gnt_valid, gnt_owner, grant, rsp_fire;
  logic [ADDR_LEN-1:0] addr_q;
  logic                wen_q;
  logic [WORD_LEN-1:0] wdata_q;

  mem_arb_pick u_pick (
    .i_valid    (i_req_valid),
    .d_valid    (d_req_valid),
    .last_owner (last_owner),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  // readies are held low while reset is asserted so nothing looks accepted
  assign grant       = rst_n && (state == IDLE) && gnt_valid;
  assign i_req_ready = grant && (gnt_owner == OWN_I);
  assign d_req_ready = grant && (gnt_owner == OWN_D);
  assign rsp_fire    = (state == WAIT) && mem_rvalid;

  assign mem_valid = (state == ISSUE);
  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)      state_nxt = ISSUE;
      ISSUE:   if (mem_ready)  state_nxt = WAIT;
      WAIT:    if (mem_rvalid) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= OWN_I;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else if (grant) begin
      owner <= gnt_owner;
      if (gnt_owner == OWN_D) begin
        addr_q  <= d_addr;
        wen_q   <= d_wen;
        wdata_q <= d_wdata;
      end else begin
        addr_q  <= i_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      i_resp_valid <= rsp_fire && (owner == OWN_I);
      d_resp_valid <= rsp_fire && (owner == OWN_D);
      if (rsp_fire && (owner == OWN_I)) i_rdata <= mem_rdata;
      if (rsp_fire && (owner == OWN_D)) d_rdata <= wen_q ? '0 : mem_rdata;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_owner <= OWN_I;
    else if (grant) last_owner <= gnt_owner;
  end
`else
  assign last_owner = OWN_I;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbiter and a behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req_valid, d_req_ready, d_wen, d_resp_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_wen(d_wen), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // transaction-level model: one outstanding request, who owns it, what it returns
  bit          busy, issued, own, o_wen, exp_i_resp, exp_d_resp, rr_last;
  logic [31:0] o_addr, o_wdata, o_exp, exp_i_rdata, exp_d_rdata;
  logic [31:0] golden [16];
  // behavioural memory
  logic [31:0] mem_arr [16];
  bit          pend, p_wen;
  int          pend_cnt, p_idx;
  // knobs
  int          rv_lo = 0, rv_hi = 0, rdy_hold = 0;
  bit          rdy_rand = 0, spur_en = 0, force_rv = 0;
  // per-step snapshot and handshake flags
  logic        last_i_ready, last_d_ready, last_mem_valid, last_mem_wen, last_i_resp, last_d_resp;
  logic [31:0] last_mem_addr, last_mem_wdata, last_i_rdata, last_d_rdata;
  bit          acc_i, acc_d;

  task automatic model_reset();
    busy = 0; issued = 0; pend = 0; exp_i_resp = 0; exp_d_resp = 0;
    exp_i_rdata = '0; exp_d_rdata = '0; rr_last = 0; rdy_hold = 0;
  endtask

  task automatic step();
    bit g_i, g_d, pref_d, fire;
    fire = pend && (pend_cnt == 0);
    mem_rdata  = $urandom;
    mem_rvalid = fire || force_rv || (!pend && spur_en && ($urandom_range(0, 3) == 0));
    if (fire && !p_wen) mem_rdata = mem_arr[p_idx];
    force_rv  = 0;
    mem_ready = (rdy_hold > 0) ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    #2;
    last_i_ready = i_req_ready;   last_d_ready = d_req_ready;
    last_mem_valid = mem_valid;   last_mem_addr = mem_addr;
    last_mem_wen = mem_wen;       last_mem_wdata = mem_wdata;
    last_i_resp = i_resp_valid;   last_d_resp = d_resp_valid;
    last_i_rdata = i_rdata;       last_d_rdata = d_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pref_d = (rr_last == 1'b0);
`else
    pref_d = 1'b1;
`endif
    g_d = !busy && d_req_valid && (pref_d || !i_req_valid);
    g_i = !busy && i_req_valid && !g_d;
    check("i_ready", i_req_ready, g_i);
    check("d_ready", d_req_ready, g_d);
    check("mem_valid", mem_valid, busy && !issued);
    if (busy && !issued) begin
      check("mem_addr", mem_addr, o_addr);
      check("mem_wen", mem_wen, o_wen);
      check("mem_wdata", mem_wdata, o_wdata);
    end
    check("i_resp", i_resp_valid, exp_i_resp);
    check("d_resp", d_resp_valid, exp_d_resp);
    check("i_rdata", i_rdata, exp_i_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    exp_i_resp = 0; exp_d_resp = 0;
    if (fire) begin
      if (own) begin exp_d_resp = 1; exp_d_rdata = o_wen ? 32'h0 : o_exp; end
      else     begin exp_i_resp = 1; exp_i_rdata = o_exp; end
      pend = 0; busy = 0; issued = 0;
    end else if (pend) pend_cnt--;
    if (mem_valid && mem_ready) begin
      issued = 1; pend = 1; pend_cnt = $urandom_range(rv_lo, rv_hi);
      p_idx = int'(mem_addr[5:2]); p_wen = mem_wen;
      if (mem_wen) mem_arr[p_idx] = mem_wdata;
    end
    if (g_d) begin
      busy = 1; own = 1; rr_last = 1; o_addr = d_addr; o_wen = d_wen; o_wdata = d_wdata;
      o_exp = golden[d_addr[5:2]];
      if (d_wen) golden[d_addr[5:2]] = d_wdata;
    end else if (g_i) begin
      busy = 1; own = 0; rr_last = 0; o_addr = i_addr; o_wen = 0; o_wdata = '0;
      o_exp = golden[i_addr[5:2]];
    end
    acc_i = i_req_valid && i_req_ready;
    acc_d = d_req_valid && d_req_ready;
    if (rdy_hold > 0) rdy_hold--;
    @(posedge clk); #1;
    cyc++;
    if (acc_i) i_req_valid = 0;
    if (acc_d) begin d_req_valid = 0; d_wen = 0; end
  endtask

  task automatic wait_acc(input bit is_d, output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (is_d ? acc_d : acc_i) begin at = cyc; break; end
    end
    check("acc_timeout", (at >= 0), 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_iready"}, i_req_ready, 0);
    check({tag, "_dready"}, d_req_ready, 0);
    check({tag, "_mvalid"}, mem_valid, 0);
    check({tag, "_maddr"}, mem_addr, 0);
    check({tag, "_mwen"}, mem_wen, 0);
    check({tag, "_mwdata"}, mem_wdata, 0);
    check({tag, "_iresp"}, i_resp_valid, 0);
    check({tag, "_dresp"}, d_resp_valid, 0);
    check({tag, "_irdata"}, i_rdata, 0);
    check({tag, "_drdata"}, d_rdata, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, mv, at, prev;
    for (int i = 0; i < 16; i++) begin golden[i] = $urandom; mem_arr[i] = golden[i]; end
    i_req_valid = 0; i_addr = '0; d_req_valid = 0; d_addr = '0; d_wen = 0; d_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset_checks("rst");
    @(posedge clk); #1 rst_n = 1;

    // single fetch, exact cycle timing
    golden[4] = 32'h0000_0513; mem_arr[4] = 32'h0000_0513;
    i_addr = 32'h10; i_req_valid = 1;
    step(); check("f_ready_c0", last_i_ready, 1);
    step(); check("f_mvalid_c1", last_mem_valid, 1);
    check("f_maddr_c1", last_mem_addr, 32'h10); check("f_mwen_c1", last_mem_wen, 0);
    step(); check("f_resp_c2", last_i_resp, 0);
    step(); check("f_resp_c3", last_i_resp, 1); check("f_rdata_c3", last_i_rdata, 32'h513);
    check("f_dresp_c3", last_d_resp, 0);
    step(); check("f_resp_c4", last_i_resp, 0);

    // store: write enable/data reach memory, one ack pulse with zero data
    d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wen = 1; d_req_valid = 1;
    step(); check("st_ready", last_d_ready, 1);
    step(); check("st_mwen", last_mem_wen, 1); check("st_mwdata", last_mem_wdata, 32'hDEAD_BEEF);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (last_d_resp) begin pulses++; check("st_rdata", last_d_rdata, 0); end
    end
    check("st_pulses", pulses, 1);

    // simultaneous fetch and load
    i_addr = 32'h20; i_req_valid = 1; d_addr = 32'h200; d_wen = 0; d_req_valid = 1;
    step();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("sim_first_i", last_i_ready, 1); check("sim_first_d", last_d_ready, 0);
`else
    check("sim_first_d", last_d_ready, 1); check("sim_first_i", last_i_ready, 0);
`endif
    for (int k = 0; k < 12 && (i_req_valid || d_req_valid); k++) step();
    check("sim_second", (i_req_valid || d_req_valid), 0);
    repeat (4) step();

    // memory stalls for 5 cycles in ISSUE
    rdy_hold = 6; i_addr = 32'h30; i_req_valid = 1;
    mv = 0; pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (last_mem_valid) mv++;
      if (last_i_resp) pulses++;
    end
    check("hold_mvalid_cycles", mv, 6);
    check("hold_resp", pulses, 1);

    // reset while waiting for the response, then a stray mem_rvalid
    rv_lo = 6; rv_hi = 6; i_addr = 32'h8; i_req_valid = 1;
    for (int k = 0; k < 20 && !issued; k++) step();
    check("rw_issued", issued, 1);
    step();
    rst_n = 0; i_req_valid = 0;
    #2 reset_checks("rw");
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    rv_lo = 0; rv_hi = 0;
    step();
    force_rv = 1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (last_i_resp || last_d_resp) pulses++;
    end
    check("rw_spurious", pulses, 0);
    i_addr = 32'h14; i_req_valid = 1;
    wait_acc(0, at);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin step(); if (last_i_resp) pulses++; end
    check("rw_after", pulses, 1);

    // back-to-back fetches with a zero-wait memory: one every 3 cycles
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      i_addr = 32'(4 * k); i_req_valid = 1;
      wait_acc(0, at);
      if (k > 0) check("b2b_spacing", at - prev, 3);
      prev = at;
    end
    repeat (4) step();

    // random traffic with random memory latency and stray responses
    rdy_rand = 1; rv_lo = 0; rv_hi = 3; spur_en = 1;
    for (int k = 0; k < 3000; k++) begin
      if (!i_req_valid && $urandom_range(0, 2) == 0) begin
        i_addr = {26'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'b00}; i_req_valid = 1;
      end
      if (!d_req_valid && $urandom_range(0, 2) == 0) begin
        d_addr = {26'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'b00};
        d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_req_valid = 1;
      end
      step();
    end
    spur_en = 0;
    for (int k = 0; k < 200 && (busy || pend || i_req_valid || d_req_valid); k++) step();
    check("drain", (busy || pend || i_req_valid || d_req_valid), 0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
